// File: rtl/aes_pkg.sv
// Shared AES definitions: datapath widths, arbiter FSM encoding and grant IDs.
package aes_pkg;

    localparam int AES_WORD_W  = 32;
    localparam int AES_STATE_W = 128;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ST_RUN = 2'd1,
        KW_RUN = 2'd2
    } fsm_e;

    typedef enum logic {
        ST  = 1'b0,
        KEY = 1'b1
    } grant_e;

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box, one byte in and one byte out, as a constant lookup table.
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign y = SBOX[a];

endmodule

// File: rtl/aes_subword.sv
// One 32-bit S-box lane: four byte S-boxes, byte i at bits 31-8i -: 8.
module aes_subword
    import aes_pkg::*;
(
    input  logic [AES_WORD_W-1:0] word,
    output logic [AES_WORD_W-1:0] sub
);

    for (genvar i = 0; i < 4; i++) begin : g_byte
        aes_sbox u_sbox (
            .a(word[AES_WORD_W-1-8*i -: 8]),
            .y(sub[AES_WORD_W-1-8*i -: 8])
        );
    end

endmodule

// File: rtl/aes_sbox_arbiter.sv
// Time-shares one SubWord lane between a 128-bit SubBytes requester (4 cycles,
// one column per cycle) and a 32-bit key SubWord requester (1 cycle).
module aes_sbox_arbiter
    import aes_pkg::*;
#(
    parameter int KEY_PRIORITY = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   st_req,
    input  logic [AES_STATE_W-1:0] st_in,
    output logic                   st_ack,
    output logic                   st_done,
    output logic [AES_STATE_W-1:0] st_out,
    input  logic                   kw_req,
    input  logic [AES_WORD_W-1:0]  kw_in,
    output logic                   kw_ack,
    output logic                   kw_done,
    output logic [AES_WORD_W-1:0]  kw_out,
    output logic                   busy
);

    fsm_e                   state;
    fsm_e                   state_next;
    grant_e                 last_grant;
    logic [1:0]             col;
    logic [AES_STATE_W-1:0] op_buf;
    logic [AES_WORD_W-1:0]  lane_in;
    logic [AES_WORD_W-1:0]  lane_out;
    logic                   st_win;

    // On a tie the state side wins only in round-robin mode and only if key went last.
    assign st_win = st_req & (~kw_req | ((KEY_PRIORITY == 0) & (last_grant == KEY)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            // NOTE: non-blocking assignments for every registered signal, so all
            // flops update together from pre-edge values regardless of block order.
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: every output of a combinational block gets a default first;
        // a path that leaves one unassigned would infer a latch.
        state_next = state;
        case (state)
            IDLE: begin
                if (st_ack) begin
                    state_next = ST_RUN;
                end else if (kw_ack) begin
                    state_next = KW_RUN;
                end
            end
            ST_RUN:  if (col == 2'd3) state_next = IDLE;
            KW_RUN:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Acks are masked during reset so every output reads 0 while rst is high.
    always_comb begin
        st_ack = 1'b0;
        kw_ack = 1'b0;
        busy   = (state != IDLE);
        if (!rst && state == IDLE) begin
            st_ack = st_win;
            kw_ack = kw_req & ~st_win;
        end
    end

    always_comb begin
        lane_in = '0;
        if (state == ST_RUN) begin
            case (col)
                2'd0: lane_in = op_buf[127:96];
                2'd1: lane_in = op_buf[95:64];
                2'd2: lane_in = op_buf[63:32];
                default: lane_in = op_buf[31:0];
            endcase
        end else if (state == KW_RUN) begin
            lane_in = op_buf[31:0];
        end
    end

    aes_subword u_lane (
        .word(lane_in),
        .sub (lane_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col        <= 2'd0;
            last_grant <= KEY;
            op_buf     <= '0;
            st_out     <= '0;
            kw_out     <= '0;
            st_done    <= 1'b0;
            kw_done    <= 1'b0;
        end else begin
            st_done <= (state == ST_RUN) && (col == 2'd3);
            kw_done <= (state == KW_RUN);

            if (st_ack) begin
                op_buf     <= st_in;
                last_grant <= ST;
            end else if (kw_ack) begin
                op_buf     <= {{(AES_STATE_W-AES_WORD_W){1'b0}}, kw_in};
                last_grant <= KEY;
            end

            // col wraps 3 -> 0 on the last column, ready for the next job.
            col <= (state == ST_RUN) ? col + 2'd1 : 2'd0;

            if (state == ST_RUN) begin
                case (col)
                    2'd0: st_out[127:96] <= lane_out;
                    2'd1: st_out[95:64]  <= lane_out;
                    2'd2: st_out[63:32]  <= lane_out;
                    default: st_out[31:0] <= lane_out;
                endcase
            end

            if (state == KW_RUN) begin
                kw_out <= lane_out;
            end
        end
    end

endmodule
